// File: rtl/switch_debounce_reader.sv
// Two-flop synchroniser, shared sample-tick prescaler and per-bit debounce
// with registered rise/fall pulses and sticky rise-event flags.
module switch_debounce_reader #(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned TICK_COUNT   = 24'd100_000,
  parameter int unsigned TICK_W       = 24,
  parameter int unsigned STABLE_TICKS = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_state,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic [WIDTH-1:0] evt_pending,
  input  logic [WIDTH-1:0] evt_clr,
  output logic             sample_tick
);

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_COUNT - 1);
  localparam logic [3:0]        CNT_LAST  = 4'(STABLE_TICKS - 1);

  logic [WIDTH-1:0]  sync1_q, sync2_q;
  logic [TICK_W-1:0] presc_q, presc_d;
  logic              tick_q, tick_d;
  logic [3:0]        cnt_q [WIDTH];
  logic [3:0]        cnt_d [WIDTH];
  logic [WIDTH-1:0]  state_q, state_d;
  logic [WIDTH-1:0]  rise_q, rise_d;
  logic [WIDTH-1:0]  fall_q, fall_d;
  logic [WIDTH-1:0]  evt_q, evt_d;

  always_comb begin
    presc_d = (presc_q == TICK_LAST) ? '0 : presc_q + 1'b1;
    // Tick is registered from the next prescaler value so it is high exactly
    // while the counter holds TICK_COUNT-1.
    tick_d  = (presc_d == TICK_LAST);
    state_d = state_q;
    rise_d  = '0;
    fall_d  = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (tick_q) begin
        if (sync2_q[i] == state_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] == CNT_LAST) begin
          state_d[i] = sync2_q[i];
          cnt_d[i]   = '0;
          rise_d[i]  = sync2_q[i];
          fall_d[i]  = ~sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 4'd1;
        end
      end
    end
    // A rise in the same cycle as a clear keeps the flag set.
    evt_d = (evt_q & ~evt_clr) | rise_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      presc_q <= '0;
      tick_q  <= 1'b0;
      state_q <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      evt_q   <= '0;
      for (int unsigned i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q <= sw_raw;
      sync2_q <= sync1_q;
      presc_q <= presc_d;
      tick_q  <= tick_d;
      state_q <= state_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      evt_q   <= evt_d;
      for (int unsigned i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign sw_state    = state_q;
  assign sw_rise     = rise_q;
  assign sw_fall     = fall_q;
  assign evt_pending = evt_q;
  assign sample_tick = tick_q;

endmodule

// File: tb/tb_switch_debounce_reader.sv
// Bench for switch_debounce_reader: window-based reference model checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_switch_debounce_reader;
  localparam int W  = 8;
  localparam int TC = 4;
  localparam int ST = 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] sw_raw = '0;
  logic [W-1:0] evt_clr = '0;
  logic [W-1:0] sw_state, sw_rise, sw_fall, evt_pending;
  logic         sample_tick;

  int tests = 0;
  int fails = 0;

  switch_debounce_reader #(
    .WIDTH(W), .TICK_COUNT(TC), .TICK_W(24), .STABLE_TICKS(ST)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sw_raw(sw_raw), .sw_state(sw_state),
    .sw_rise(sw_rise), .sw_fall(sw_fall), .evt_pending(evt_pending),
    .evt_clr(evt_clr), .sample_tick(sample_tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a level is accepted when the last ST tick samples of the
  // synchronised input all differ from the current accepted level.
  logic [W-1:0] m_r1, m_r2, m_state, m_rise, m_fall, m_evt, m_diff;
  logic [W-1:0] m_win [ST];
  int           m_n;
  bit           m_tick;
  bit           m_valid = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_r1 = '0; m_r2 = '0; m_state = '0; m_rise = '0; m_fall = '0; m_evt = '0;
      for (int i = 0; i < ST; i++) m_win[i] = '0;
      m_n = 0; m_tick = 1'b0; m_valid = 1'b1;
    end else if (m_valid) begin
      m_evt  = (m_evt & ~evt_clr) | m_rise;
      m_rise = '0;
      m_fall = '0;
      if (m_tick) begin
        for (int i = ST - 1; i > 0; i--) m_win[i] = m_win[i-1];
        m_win[0] = m_r2;
        m_diff = '1;
        for (int i = 0; i < ST; i++) m_diff = m_diff & (m_win[i] ^ m_state);
        m_rise  = m_diff & ~m_state;
        m_fall  = m_diff & m_state;
        m_state = m_state ^ m_diff;
      end
      m_r2 = m_r1;
      m_r1 = sw_raw;
      m_n++;
      m_tick = ((m_n % TC) == TC - 1);
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("model_state", 32'(sw_state), 32'(m_state));
      chk("model_rise", 32'(sw_rise), 32'(m_rise));
      chk("model_fall", 32'(sw_fall), 32'(m_fall));
      chk("model_evt", 32'(evt_pending), 32'(m_evt));
      chk("model_tick", 32'(sample_tick), 32'(m_tick));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int k;

    // Reset held for 3 edges, then tick pattern and quiet outputs.
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rst_state", 32'(sw_state), 32'h0);
    chk("rst_evt", 32'(evt_pending), 32'h0);
    for (int c = 0; c < 50; c++) begin
      chk("tick_phase", 32'(sample_tick), 32'((c % 4) == 3));
      chk("idle_pulses", 32'(sw_rise | sw_fall), 32'h0);
      step();
    end

    // Clean press on bit 0.
    sw_raw[0] = 1'b1;
    k = 0;
    for (int i = 1; i <= 40; i++) begin
      step();
      k = i;
      if (sw_state[0]) break;
    end
    chk("press_lat_ge11", 32'(k >= 11), 32'h1);
    chk("press_lat_le15", 32'(k <= 15), 32'h1);
    chk("press_rise", 32'(sw_rise[0]), 32'h1);
    step();
    chk("press_rise_1cyc", 32'(sw_rise[0]), 32'h0);
    chk("press_evt", 32'(evt_pending[0]), 32'h1);
    repeat (10) step();
    chk("press_evt_hold", 32'(evt_pending[0]), 32'h1);

    // Short glitch on bit 3.
    sw_raw[3] = 1'b1;
    repeat (6) step();
    sw_raw[3] = 1'b0;
    repeat (30) step();
    chk("glitch_state", 32'(sw_state[3]), 32'h0);
    // Toggle every sample period so never 3 consecutive ticks see a 1.
    for (int j = 0; j < 16; j++) begin
      sw_raw[3] = ~sw_raw[3];
      repeat (4) step();
    end
    repeat (20) step();
    chk("toggle_state", 32'(sw_state[3]), 32'h0);

    // Release bit 0.
    sw_raw[0] = 1'b0;
    k = 0;
    for (int i = 1; i <= 40; i++) begin
      step();
      k = i;
      if (sw_fall[0]) break;
    end
    chk("fall_lat_ge11", 32'(k >= 11), 32'h1);
    chk("fall_lat_le15", 32'(k <= 15), 32'h1);
    chk("fall_state", 32'(sw_state[0]), 32'h0);
    step();
    chk("fall_1cyc", 32'(sw_fall[0]), 32'h0);
    chk("fall_evt_kept", 32'(evt_pending), 32'h01);

    // Clear handshake, then clear coincident with a rise.
    evt_clr[0] = 1'b1;
    step();
    evt_clr[0] = 1'b0;
    chk("clr_evt", 32'(evt_pending), 32'h00);
    sw_raw[5] = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step();
      if (m_rise[5]) break;
    end
    chk("rise5_seen", 32'(sw_rise[5]), 32'h1);
    evt_clr[5] = 1'b1;
    step();
    evt_clr[5] = 1'b0;
    chk("set_wins", 32'(evt_pending[5]), 32'h1);

    // Reset during debounce, then fresh debounce of all bits.
    sw_raw = 8'hFF;
    repeat (8) step();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("mid_rst_state", 32'(sw_state), 32'h0);
    chk("mid_rst_evt", 32'(evt_pending), 32'h0);
    chk("mid_rst_tick", 32'(sample_tick), 32'h0);
    k = 0;
    for (int i = 1; i <= 40; i++) begin
      step();
      k = i;
      if (sw_rise == 8'hFF) break;
    end
    chk("fresh_lat", 32'(k), 32'd12);
    chk("fresh_state", 32'(sw_state), 32'hFF);
    step();
    chk("fresh_evt", 32'(evt_pending), 32'hFF);
    repeat (5) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
